// File: rtl/cpu_io_pkg.sv
// Shared constants for the CPU's external I/O path.
//   WORD_W       : datapath / bus word width
//   IN_PORT_ID   : port identifier of the input port
//   OUT_PORT_ID  : port identifier of the output port
//   CLEAR_ACTIVE : level of the active-low 'clear' reset shared by clear-driven blocks
package cpu_io_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IN_PORT_ID  = 2'd0,
    OUT_PORT_ID = 2'd1
  } port_id_e;

  localparam logic CLEAR_ACTIVE = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy counter.
//   clock   : rising-edge clock
//   clear   : synchronous reset (CLEAR_ACTIVE level); resets pointers and count only
//   wr_en   : push request, ignored while full
//   wr_data : word to push
//   rd_en   : pop request, ignored while empty
//   rd_data : current head word (combinational from storage)
//   count   : occupancy 0..DEPTH
//   full    : count == DEPTH
//   empty   : count == 0
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  import cpu_io_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Full/empty come from the counter; pointers alone cannot tell them apart.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (clear == CLEAR_ACTIVE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; writes are blocked during reset so nothing lands.
  always_ff @(posedge clock) begin
    if (push && (clear != CLEAR_ACTIVE)) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/in_port_unit.sv
// Input port of the CPU I/O path: device words enter a FIFO via valid/ready
// and the datapath pops one word per cycle of InPortout.
//   clock           : rising-edge clock
//   clear           : synchronous active-low reset
//   dev_data        : word offered by the device
//   dev_valid       : device word valid
//   dev_ready       : FIFO can accept a word (depends on occupancy only)
//   InPortout       : datapath read strobe, pops one word per asserted cycle
//   BusMuxIn_InPort : FIFO head, or last popped word when empty
//   InPortAvail     : FIFO not empty
//   in_count        : occupancy 0..DEPTH
//   rd_underflow    : sticky, set by a read while empty
module in_port_unit #(
  parameter int unsigned WORD_W = cpu_io_pkg::WORD_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [WORD_W-1:0] dev_data,
  input  logic              dev_valid,
  output logic              dev_ready,
  input  logic              InPortout,
  output logic [WORD_W-1:0] BusMuxIn_InPort,
  output logic              InPortAvail,
  output logic [CNT_W-1:0]  in_count,
  output logic              rd_underflow
);
  import cpu_io_pkg::*;

  logic [WORD_W-1:0] head;
  logic [WORD_W-1:0] last_word;
  logic              full;
  logic              empty;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock   (clock),
    .clear   (clear),
    .wr_en   (dev_valid),
    .wr_data (dev_data),
    .rd_en   (InPortout),
    .rd_data (head),
    .count   (in_count),
    .full    (full),
    .empty   (empty)
  );

  assign dev_ready       = ~full;
  assign InPortAvail     = ~empty;
  assign BusMuxIn_InPort = empty ? last_word : head;

  always_ff @(posedge clock) begin
    if (clear == CLEAR_ACTIVE) begin
      last_word    <= '0;
      rd_underflow <= 1'b0;
    end else if (InPortout) begin
      if (!empty) last_word    <= head;
      else        rd_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_in_port_unit.sv
module tb_in_port_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] dev_data;
  logic        dev_valid;
  logic        dev_ready;
  logic        InPortout;
  logic [31:0] BusMuxIn_InPort;
  logic        InPortAvail;
  logic [2:0]  in_count;
  logic        rd_underflow;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    bit        chk;
    bit        clr;
    bit        vld;
    bit [31:0] data;
    bit        rd;
    bit        e_ready;
    bit        e_avail;
    bit [2:0]  e_count;
    bit [31:0] e_bus;
    bit        e_uf;
  } vec_t;

  vec_t vecs[$];

  in_port_unit #(.WORD_W(32), .DEPTH(4)) dut (
    .clock           (clock),
    .clear           (clear),
    .dev_data        (dev_data),
    .dev_valid       (dev_valid),
    .dev_ready       (dev_ready),
    .InPortout       (InPortout),
    .BusMuxIn_InPort (BusMuxIn_InPort),
    .InPortAvail     (InPortAvail),
    .in_count        (in_count),
    .rd_underflow    (rd_underflow)
  );

  always #5 clock = ~clock;

  // Row: inputs for this cycle, plus the outputs expected just before its edge.
  task automatic add(input bit chk, input bit clr, input bit vld, input bit [31:0] data,
                     input bit rd, input bit e_ready, input bit e_avail,
                     input bit [2:0] e_count, input bit [31:0] e_bus, input bit e_uf);
    vec_t v;
    v.chk = chk; v.clr = clr; v.vld = vld; v.data = data; v.rd = rd;
    v.e_ready = e_ready; v.e_avail = e_avail; v.e_count = e_count;
    v.e_bus = e_bus; v.e_uf = e_uf;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit clr, input bit vld, input bit [31:0] data, input bit rd);
    @(negedge clock);
    clear = clr; dev_valid = vld; dev_data = data; InPortout = rd;
    #1;
  endtask

  task automatic check(input string tag, input bit e_ready, input bit e_avail,
                       input bit [2:0] e_count, input bit [31:0] e_bus, input bit e_uf);
    checks++;
    if (dev_ready !== e_ready) begin
      failures++; $display("FAIL %s dev_ready got %b want %b", tag, dev_ready, e_ready);
    end
    checks++;
    if (InPortAvail !== e_avail) begin
      failures++; $display("FAIL %s InPortAvail got %b want %b", tag, InPortAvail, e_avail);
    end
    checks++;
    if (in_count !== e_count) begin
      failures++; $display("FAIL %s in_count got %0d want %0d", tag, in_count, e_count);
    end
    checks++;
    if (BusMuxIn_InPort !== e_bus) begin
      failures++; $display("FAIL %s bus got %h want %h", tag, BusMuxIn_InPort, e_bus);
    end
    checks++;
    if (rd_underflow !== e_uf) begin
      failures++; $display("FAIL %s rd_underflow got %b want %b", tag, rd_underflow, e_uf);
    end
  endtask

  initial begin
    clear = 1'b0; dev_valid = 1'b0; dev_data = '0; InPortout = 1'b0;

    //  chk clr vld data          rd  rdy avl cnt bus           uf
    // reset for two edges while a device word is offered
    add(0, 0, 1, 32'hDEAD_BEEF, 0,  1,  0,  0, 32'h0,        0);
    add(1, 0, 1, 32'hDEAD_BEEF, 0,  1,  0,  0, 32'h0,        0);
    add(1, 1, 0, 32'h0,         0,  1,  0,  0, 32'h0,        0);
    // single transfer
    add(1, 1, 1, 32'h42,        0,  1,  0,  0, 32'h0,        0);
    add(1, 1, 0, 32'h0,         1,  1,  1,  1, 32'h42,       0);
    add(1, 1, 0, 32'h0,         0,  1,  0,  0, 32'h42,       0);
    // fill, refused fifth push, pop, refill and wrap
    add(1, 1, 1, 32'd1,         0,  1,  0,  0, 32'h42,       0);
    add(1, 1, 1, 32'd2,         0,  1,  1,  1, 32'd1,        0);
    add(1, 1, 1, 32'd3,         0,  1,  1,  2, 32'd1,        0);
    add(1, 1, 1, 32'd4,         0,  1,  1,  3, 32'd1,        0);
    add(1, 1, 1, 32'd5,         0,  0,  1,  4, 32'd1,        0);
    add(1, 1, 0, 32'h0,         1,  0,  1,  4, 32'd1,        0);
    add(1, 1, 0, 32'h0,         0,  1,  1,  3, 32'd2,        0);
    add(1, 1, 1, 32'd5,         0,  1,  1,  3, 32'd2,        0);
    add(1, 1, 0, 32'h0,         1,  0,  1,  4, 32'd2,        0);
    add(1, 1, 0, 32'h0,         1,  1,  1,  3, 32'd3,        0);
    add(1, 1, 0, 32'h0,         1,  1,  1,  2, 32'd4,        0);
    add(1, 1, 0, 32'h0,         1,  1,  1,  1, 32'd5,        0);
    add(1, 1, 0, 32'h0,         0,  1,  0,  0, 32'd5,        0);
    // simultaneous push and pop at count=2
    add(1, 1, 1, 32'h10,        0,  1,  0,  0, 32'd5,        0);
    add(1, 1, 1, 32'h11,        0,  1,  1,  1, 32'h10,       0);
    add(1, 1, 1, 32'hA5,        1,  1,  1,  2, 32'h10,       0);
    add(1, 1, 0, 32'h0,         1,  1,  1,  2, 32'h11,       0);
    add(1, 1, 0, 32'h0,         1,  1,  1,  1, 32'hA5,       0);
    add(1, 1, 0, 32'h0,         0,  1,  0,  0, 32'hA5,       0);
    // underflow with a push in the same cycle (no bypass)
    add(1, 1, 1, 32'h77,        1,  1,  0,  0, 32'hA5,       0);
    add(1, 1, 0, 32'h0,         0,  1,  1,  1, 32'h77,       1);
    add(1, 1, 0, 32'h0,         1,  1,  1,  1, 32'h77,       1);
    add(1, 1, 0, 32'h0,         0,  1,  0,  0, 32'h77,       1);
    // reset with count=3, handshake and read in the reset cycle ignored
    add(1, 1, 1, 32'd1,         0,  1,  0,  0, 32'h77,       1);
    add(1, 1, 1, 32'd2,         0,  1,  1,  1, 32'd1,        1);
    add(1, 1, 1, 32'd3,         0,  1,  1,  2, 32'd1,        1);
    add(1, 0, 1, 32'd4,         1,  1,  1,  3, 32'd1,        1);
    add(1, 1, 0, 32'h0,         0,  1,  0,  0, 32'h0,        0);
    add(1, 1, 1, 32'h9,         0,  1,  0,  0, 32'h0,        0);
    add(1, 1, 0, 32'h0,         1,  1,  1,  1, 32'h9,        0);
    add(1, 1, 0, 32'h0,         0,  1,  0,  0, 32'h9,        0);

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].vld, vecs[i].data, vecs[i].rd);
      if (vecs[i].chk)
        check($sformatf("row%0d", i), vecs[i].e_ready, vecs[i].e_avail,
              vecs[i].e_count, vecs[i].e_bus, vecs[i].e_uf);
    end

    // Full FIFO with push and pop together: push refused, ready returns next cycle.
    for (int unsigned k = 0; k < 4; k++) drive(1'b1, 1'b1, 32'h100 + k, 1'b0);
    drive(1'b1, 1'b1, 32'hBAD, 1'b1);
    check("full_pop", 1'b0, 1'b1, 3'd4, 32'h100, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    check("full_after", 1'b1, 1'b1, 3'd3, 32'h101, 1'b0);
    for (int unsigned k = 1; k < 4; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      check($sformatf("drain%0d", k), 1'b1, 1'b1, 3'(4 - k), 32'h100 + k, 1'b0);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    check("drained", 1'b1, 1'b0, 3'd0, 32'h103, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
